// File: rtl/cr16_pkg.sv
// Shared CR16 execute-path definitions: PSR flag bit positions, branch
// condition codes and the flag vector type.
package cr16_pkg;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_HI = 4'h4;
  localparam logic [3:0] COND_LS = 4'h5;
  localparam logic [3:0] COND_GT = 4'h6;
  localparam logic [3:0] COND_LE = 4'h7;
  localparam logic [3:0] COND_FS = 4'h8;
  localparam logic [3:0] COND_FC = 4'h9;
  localparam logic [3:0] COND_LO = 4'hA;
  localparam logic [3:0] COND_HS = 4'hB;
  localparam logic [3:0] COND_LT = 4'hC;
  localparam logic [3:0] COND_GE = 4'hD;
  localparam logic [3:0] COND_UC = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // {C,L,F,Z,N}, bit4..bit0
  typedef logic [4:0] flags_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// ALU result input channel and register-file writeback channel.
// master = upstream ALU / register-file side, slave = the result stage.
interface alu_result_stage_if
  import cr16_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_s;
  flags_t            in_clfzn;
  flags_t            in_flag_mask;
  logic              in_wen;
  logic [ADDR_W-1:0] in_waddr;

  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output in_valid, in_s, in_clfzn, in_flag_mask, in_wen, in_waddr, wb_ready,
    input  in_ready, wb_valid, wb_addr, wb_data
  );

  modport slave (
    input  in_valid, in_s, in_clfzn, in_flag_mask, in_wen, in_waddr, wb_ready,
    output in_ready, wb_valid, wb_addr, wb_data
  );

endinterface

// File: rtl/alu_result_stage_cond_eval.sv
// Branch condition evaluation from the PSR; purely combinational so the
// branch unit can reuse it directly.
module cond_eval
  import cr16_pkg::*;
(
  input  flags_t     psr,
  input  logic [3:0] cond,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_EQ: cond_true = psr[FLAG_Z];
      COND_NE: cond_true = !psr[FLAG_Z];
      COND_CS: cond_true = psr[FLAG_C];
      COND_CC: cond_true = !psr[FLAG_C];
      COND_HI: cond_true = psr[FLAG_L];
      COND_LS: cond_true = !psr[FLAG_L];
      COND_GT: cond_true = psr[FLAG_N];
      COND_LE: cond_true = !psr[FLAG_N];
      COND_FS: cond_true = psr[FLAG_F];
      COND_FC: cond_true = !psr[FLAG_F];
      COND_LO: cond_true = !psr[FLAG_L] && !psr[FLAG_Z];
      COND_HS: cond_true = psr[FLAG_L] || psr[FLAG_Z];
      COND_LT: cond_true = !psr[FLAG_N] && !psr[FLAG_Z];
      COND_GE: cond_true = psr[FLAG_N] || psr[FLAG_Z];
      COND_UC: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: PSR flag update, carry return, 2-entry writeback queue
// and branch condition. Optional PSR load port under ALU_RESULT_STAGE_PSR_WRITE_EN.
module alu_result_stage
  import cr16_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2
) (
  input  logic       clk,
  input  logic       reset,
  alu_result_stage_if.slave bus,
  output flags_t     psr_flags,
  output logic       carry_to_alu,
  input  logic [3:0] cond,
  output logic       cond_true
`ifdef ALU_RESULT_STAGE_PSR_WRITE_EN
  ,
  input  logic       psr_we,
  input  flags_t     psr_wdata
`endif
);

  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  logic [1:0]        cnt_p0;
  logic [1:0]        cnt_nxt;
  logic              rdy_p0;
  flags_t            psr_p0;
  flags_t            psr_nxt;
  logic [ADDR_W-1:0] head_addr_p0;
  logic [DATA_W-1:0] head_data_p0;
  logic [ADDR_W-1:0] tail_addr_p0;
  logic [DATA_W-1:0] tail_data_p0;
  logic              vld_p0;
  logic              accept;
  logic              push;
  logic              pop;

  assign vld_p0  = (cnt_p0 != 2'd0);
  assign accept  = bus.in_valid & rdy_p0;
  assign push    = accept & bus.in_wen;
  assign pop     = vld_p0 & bus.wb_ready;
  assign cnt_nxt = cnt_p0 + {1'b0, push} - {1'b0, pop};

  always_comb begin
    psr_nxt = psr_p0;
    if (accept) begin
      psr_nxt = (psr_p0 & ~bus.in_flag_mask) | (bus.in_clfzn & bus.in_flag_mask);
    end
`ifdef ALU_RESULT_STAGE_PSR_WRITE_EN
    if (psr_we) begin
      psr_nxt = psr_wdata;
    end
`endif
  end

  // Stage p0: head entry, occupancy, ready and PSR registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p0       <= 2'd0;
      rdy_p0       <= 1'b1;
      psr_p0       <= '0;
      head_addr_p0 <= '0;
      head_data_p0 <= '0;
    end else begin
      cnt_p0 <= cnt_nxt;
      rdy_p0 <= (cnt_nxt < DEPTH_C);
      psr_p0 <= psr_nxt;
      // A new entry lands in the head when it is, or is about to become, empty
      if (push && (cnt_p0 == 2'd0 || (cnt_p0 == 2'd1 && pop))) begin
        head_addr_p0 <= bus.in_waddr;
        head_data_p0 <= bus.in_s;
      end else if (pop && cnt_p0 == 2'd2) begin
        head_addr_p0 <= tail_addr_p0;
        head_data_p0 <= tail_data_p0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && cnt_p0 == 2'd1 && !pop) begin
      tail_addr_p0 <= bus.in_waddr;
      tail_data_p0 <= bus.in_s;
    end
  end

  assign bus.in_ready = rdy_p0;
  assign bus.wb_valid = vld_p0;
  assign bus.wb_addr  = head_addr_p0;
  assign bus.wb_data  = head_data_p0;
  assign psr_flags    = psr_p0;
  assign carry_to_alu = psr_p0[FLAG_C];

  cond_eval u_cond_eval (
    .psr      (psr_p0),
    .cond     (cond),
    .cond_true(cond_true)
  );

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios then random traffic,
// checked against a queue-based reference model.
module tb_alu_result_stage;

  logic       clk;
  logic       reset;
  logic [4:0] psr_flags;
  logic       carry_to_alu;
  logic [3:0] cond;
  logic       cond_true;
`ifdef ALU_RESULT_STAGE_PSR_WRITE_EN
  logic       psr_we;
  logic [4:0] psr_wdata;
`endif

  alu_result_stage_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  alu_result_stage #(.DATA_W(16), .ADDR_W(4), .DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .psr_flags   (psr_flags),
    .carry_to_alu(carry_to_alu),
    .cond        (cond),
    .cond_true   (cond_true)
`ifdef ALU_RESULT_STAGE_PSR_WRITE_EN
    ,
    .psr_we      (psr_we),
    .psr_wdata   (psr_wdata)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [19:0] mq[$];
  logic [4:0]  mpsr;

  function automatic logic cond_ref(input logic [4:0] p, input logic [3:0] c);
    logic fc, fl, ff, fz, fn;
    {fc, fl, ff, fz, fn} = p;
    case (c)
      4'h0: return fz;
      4'h1: return !fz;
      4'h2: return fc;
      4'h3: return !fc;
      4'h4: return fl;
      4'h5: return !fl;
      4'h6: return fn;
      4'h7: return !fn;
      4'h8: return ff;
      4'h9: return !ff;
      4'hA: return !fl && !fz;
      4'hB: return fl || fz;
      4'hC: return !fn && !fz;
      4'hD: return fn || fz;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] s, input logic [4:0] fl,
                       input logic [4:0] mask, input logic wen, input logic [3:0] wa);
    bus.in_valid     = v;
    bus.in_s         = s;
    bus.in_clfzn     = fl;
    bus.in_flag_mask = mask;
    bus.in_wen       = wen;
    bus.in_waddr     = wa;
  endtask

  // Check outputs against the model, advance the model, then move to the next cycle.
  task automatic tick();
    logic acc;
    logic pp;
    #1;
    chk("in_ready", bus.in_ready, mq.size() < 2);
    chk("wb_valid", bus.wb_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("wb_addr", bus.wb_addr, mq[0][19:16]);
      chk("wb_data", bus.wb_data, mq[0][15:0]);
    end
    chk("psr", psr_flags, mpsr);
    chk("carry", carry_to_alu, mpsr[4]);
    chk("cond_true", cond_true, cond_ref(mpsr, cond));
    if (reset) begin
      mq.delete();
      mpsr = 5'b0;
    end else begin
      acc = bus.in_valid && (mq.size() < 2);
      pp  = bus.wb_ready && (mq.size() != 0);
      if (pp) void'(mq.pop_front());
      if (acc && bus.in_wen) mq.push_back({bus.in_waddr, bus.in_s});
      if (acc) mpsr = (mpsr & ~bus.in_flag_mask) | (bus.in_clfzn & bus.in_flag_mask);
`ifdef ALU_RESULT_STAGE_PSR_WRITE_EN
      if (psr_we) mpsr = psr_wdata;
`endif
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    cond  = 4'h0;
    bus.wb_ready = 1'b1;
    drive(0, 16'h0, 5'h0, 5'h0, 0, 4'h0);
`ifdef ALU_RESULT_STAGE_PSR_WRITE_EN
    psr_we    = 1'b0;
    psr_wdata = 5'b0;
`endif
    mpsr = 5'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // reset state
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_wb_addr", bus.wb_addr, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_psr", psr_flags, 0);

    // ADD producing Z
    drive(1, 16'h0000, 5'b00010, 5'b10110, 1, 4'd3);
    tick();
    chk("add_wb_valid", bus.wb_valid, 1);
    chk("add_wb_addr", bus.wb_addr, 3);
    chk("add_wb_data", bus.wb_data, 0);
    chk("add_psr", psr_flags, 5'b00010);
    chk("add_eq", cond_true, 1);

    // carry chain: ADDU sets C, then AND with empty mask leaves PSR alone
    drive(1, 16'h1234, 5'b10000, 5'b10001, 1, 4'd5);
    tick();
    chk("addu_carry", carry_to_alu, 1);
    drive(1, 16'h00ff, 5'b00000, 5'b00000, 1, 4'd6);
    tick();
    chk("and_psr", psr_flags, 5'b10010);
    chk("and_carry", carry_to_alu, 1);
    drive(0, 16'h0, 5'h0, 5'h0, 0, 4'h0);
    repeat (3) tick();

    // backpressure
    bus.wb_ready = 1'b0;
    drive(1, 16'h1111, 5'h0, 5'h0, 1, 4'd1);
    tick();
    drive(1, 16'h2222, 5'h0, 5'h0, 1, 4'd2);
    tick();
    drive(1, 16'h3333, 5'b11111, 5'b11111, 1, 4'd7);
    chk("bp_full_ready", bus.in_ready, 0);
    tick();
    chk("bp_psr_held", psr_flags, 5'b10010);
    bus.wb_ready = 1'b1;
    tick();
    chk("bp_second", bus.wb_data, 16'h2222);
    tick();
    chk("bp_third", bus.wb_data, 16'h3333);
    chk("bp_third_psr", psr_flags, 5'b11111);
    drive(0, 16'h0, 5'h0, 5'h0, 0, 4'h0);
    tick();

    // simultaneous push/pop at count=1
    bus.wb_ready = 1'b0;
    drive(1, 16'hA000, 5'h0, 5'h0, 1, 4'd8);
    tick();
    bus.wb_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      drive(1, 16'hA000 + 16'(i), 5'h0, 5'h0, 1, 4'(i));
      tick();
      chk("pp_valid", bus.wb_valid, 1);
      chk("pp_ready", bus.in_ready, 1);
      chk("pp_data", bus.wb_data, 16'hA000 + 16'(i));
    end
    drive(0, 16'h0, 5'h0, 5'h0, 0, 4'h0);
    repeat (2) tick();

    // flags-only update, nothing enqueued
    drive(1, 16'hBEEF, 5'b00010, 5'b00010, 0, 4'd9);
    tick();
    drive(0, 16'h0, 5'h0, 5'h0, 0, 4'h0);
    chk("wen0_valid", bus.wb_valid, 0);
    chk("wen0_z", psr_flags[1], 1);
    tick();

    // reset with two queued entries
    bus.wb_ready = 1'b0;
    drive(1, 16'h5555, 5'b10101, 5'b11111, 1, 4'd4);
    tick();
    tick();
    drive(0, 16'h0, 5'h0, 5'h0, 0, 4'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_valid", bus.wb_valid, 0);
    chk("mrst_psr", psr_flags, 0);
    chk("mrst_addr", bus.wb_addr, 0);
    chk("mrst_data", bus.wb_data, 0);
    chk("mrst_ready", bus.in_ready, 1);
    bus.wb_ready = 1'b1;
    tick();

`ifdef ALU_RESULT_STAGE_PSR_WRITE_EN
    psr_we    = 1'b1;
    psr_wdata = 5'b10101;
    drive(1, 16'h7777, 5'b01010, 5'b11111, 1, 4'd2);
    tick();
    psr_we = 1'b0;
    drive(0, 16'h0, 5'h0, 5'h0, 0, 4'h0);
    chk("psrwe_prio", psr_flags, 5'b10101);
    tick();
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 5'($urandom), 5'($urandom),
            1'($urandom_range(0, 3) != 0), 4'($urandom));
      bus.wb_ready = 1'($urandom_range(0, 2) != 0);
      cond = 4'($urandom);
`ifdef ALU_RESULT_STAGE_PSR_WRITE_EN
      psr_we    = ($urandom_range(0, 9) == 0);
      psr_wdata = 5'($urandom);
`endif
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Sits directly downstream of the 16-bit ALU in the execute path.
- Captures the ALU result S and the flag vector CLFZN.
- Maintains the program status register (PSR) flags and returns the carry to the ALU for ADDC/ADDCI/ADDCU/ADDCUI.
- Buffers register-file writebacks in a 2-entry in-order queue with valid/ready handshake, and evaluates branch conditions from the PSR.

Parameters:
- DATA_W, 16, result/writeback data width
- ADDR_W, 4, register-file address width (16 registers)
- DEPTH, 2, writeback queue depth (fixed at 2; other values not supported)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  ALU result valid this cycle
- in_ready  out  1  stage can accept (registered)
- in_s  in  DATA_W  ALU result S
- in_clfzn  in  5  ALU flags {C,L,F,Z,N} (bit4..bit0)
- in_flag_mask  in  5  per-flag update enable from decoder, same bit order
- in_wen  in  1  result is written to the register file
- in_waddr  in  ADDR_W  destination register
- wb_valid  out  1  head entry valid
- wb_ready  in  1  register file accepts head entry
- wb_addr  out  ADDR_W  head destination
- wb_data  out  DATA_W  head data
- psr_flags  out  5  current PSR {C,L,F,Z,N}
- carry_to_alu  out  1  equals psr_flags[4]
- cond  in  4  condition code for the branch unit
- cond_true  out  1  combinational condition result

Behaviour:
- Reset: queue count=0, wb_valid=0, wb_addr=0, wb_data=0, psr_flags=0, in_ready=1. A reset asserted mid-operation discards all queued entries; there is no partial drain.
- Accept condition: accept = in_valid & in_ready, with in_ready = (count<2), registered.
- On accept, flags update next edge: psr[i] <= in_clfzn[i] where in_flag_mask[i]=1, else psr[i] holds.
  - The ALU reports all-zero flags for logical ops; the decoder masks those off, so logical ops do not clear flags.
  - Back-to-back accepts: the flags from cycle n are visible on carry_to_alu in cycle n+1.
- Enqueue rule: on accept with in_wen=1, {in_waddr,in_s} is enqueued. With in_wen=0, only flags update and nothing is enqueued.
- Latency: an entry accepted at edge k appears with wb_valid=1 after edge k (one cycle) when the queue was empty.
- Pop: wb_valid & wb_ready pops the head at the edge.
- Simultaneous push and pop:
  - count=1: count stays 1; the new entry becomes the head next cycle.
  - count=2: in_ready=0, so no push is possible.
- Ordering: strict FIFO. wb_addr/wb_data hold stable while wb_valid=1 and wb_ready=0.
- in_valid with in_ready=0: input ignored. PSR unchanged. The upstream stage must hold.
- cond_true, from cond (Z=psr[1], C=psr[4], L=psr[3], N=psr[0], F=psr[2]):
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 HI: L
  - 5 LS: !L
  - 6 GT: N
  - 7 LE: !N
  - 8 FS: F
  - 9 FC: !F
  - A LO: !L&!Z
  - B HS: L|Z
  - C LT: !N&!Z
  - D GE: N|Z
  - E UC: 1
  - F: 0
- Width rule: no arithmetic is performed here; data passes through unmodified.

Optional Feature:
- Macro: ALU_RESULT_STAGE_PSR_WRITE_EN.
- Enabled:
  - Adds input ports psr_we (1) and psr_wdata (5) for the load-PSR instruction.
  - psr_we=1 loads all 5 bits at the next edge.
  - psr_we has priority over any simultaneous accepted flag update.
- Disabled: ports absent; the PSR changes only via accepted ALU results.

Decomposition:
- Package cr16_pkg:
  - Flag bit index constants FLAG_C=4, FLAG_L=3, FLAG_F=2, FLAG_Z=1, FLAG_N=0.
  - 4-bit condition-code constants COND_EQ..COND_NV.
  - Typedef for the 5-bit flag vector.
- One sub-module, cond_eval: purely combinational (psr, cond) -> cond_true. It is shared with the future branch unit.

Test Plan:
- Reset, then ADD: in_s=16'h0000, clfzn=5'b00010, mask=5'b10110, wen=1, waddr=3 -> next cycle wb_valid=1, wb_addr=3, wb_data=0, psr=5'b00010; cond=0 gives cond_true=1.
- Carry chain: ADDU accepted with clfzn C=1, mask C set -> carry_to_alu=1 the following cycle; a subsequent AND with mask=0 leaves psr unchanged.
- Backpressure: wb_ready=0, push 3 results (0x1111, 0x2222, 0x3333) -> first two accepted, in_ready=0 on the third; wb_ready=1 -> drains 0x1111 then 0x2222; the third is accepted afterwards, in order.
- Simultaneous push/pop at count=1 for 10 cycles -> count stays 1, data streams in order, no loss or duplication.
- wen=0 with mask=5'b00010, clfzn Z=1 -> psr Z=1, no wb_valid pulse.
- Reset asserted with 2 queued entries -> wb_valid=0 and psr=0 next cycle. With ALU_RESULT_STAGE_PSR_WRITE_EN, psr_we=1 with psr_wdata=5'b10101 concurrent with an accepted update -> psr=5'b10101.
